// File: rtl/vga_pkg.sv
// vga_pkg
// Shared constants for the VGA front end: renderer tile/map geometry and the
// default 640x480@60 timing, plus a helper that sums one axis of a timing
// description into its total period.
// Ports: none (package).
package vga_pkg;

  // Tile/map geometry used by the renderer and address generator.
  localparam int TILE_W   = 16;
  localparam int TILE_H   = 16;
  localparam int MAP_COLS = 40;
  localparam int MAP_ROWS = 30;

  // Coordinate width of the timing counters and their outputs.
  localparam int CORD_W = 10;

  // Default 640x480@60 timing (25 MHz pixel tick).
  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int SYNC_DELAY_DEF = 2;

  function automatic int line_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = line_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int V_TOTAL = line_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_delay_line.sv
// vga_delay_line
// Clock-enabled shift register that lines up the sync/blank strobes with the
// pixel data pipeline (address generator -> ROM -> RGB). Each stage advances
// only when en is high; a synchronous reset loads every stage with RST_VAL.
// DEPTH = 0 is a plain wire from d to q.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   en   - stage advance enable (pixel tick)
//   d    - WIDTH-bit input
//   q    - WIDTH-bit output, DEPTH ticks behind d
module vga_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst, en};
    assign q = d;
  end else begin : g_stages
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else if (en) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// VGA raster timing: horizontal/vertical counters advanced by a pixel tick,
// active-area flag, active-low sync pulses and blank delayed to match the
// pixel pipeline, and a one-clock frame_start strobe at the start of
// vertical blanking for game-logic updates.
// Note the naming: o_x_cord carries the line (vertical) count and o_y_cord
// the pixel-within-line (horizontal) count.
// Ports:
//   i_clk         - clock, rising edge
//   i_rst         - synchronous active-high reset
//   i_pix_en      - pixel tick / clock enable
//   o_x_cord      - current line, 0..V_TOTAL-1
//   o_y_cord      - current pixel in line, 0..H_TOTAL-1
//   o_show_en     - coordinate is inside the active area
//   o_hsync_n     - delayed active-low horizontal sync
//   o_vsync_n     - delayed active-low vertical sync
//   o_blank_n     - delayed copy of o_show_en for the DAC
//   o_frame_start - one-clock pulse when the raster enters vertical blanking
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_DEF,
  parameter int H_FP       = H_FP_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BP       = H_BP_DEF,
  parameter int V_ACTIVE   = V_ACTIVE_DEF,
  parameter int V_FP       = V_FP_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BP       = V_BP_DEF,
  parameter int SYNC_DELAY = SYNC_DELAY_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_pix_en,
  output logic [CORD_W-1:0] o_x_cord,
  output logic [CORD_W-1:0] o_y_cord,
  output logic              o_show_en,
  output logic              o_hsync_n,
  output logic              o_vsync_n,
  output logic              o_blank_n,
  output logic              o_frame_start
);

  localparam int H_TOT = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOT = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CORD_W-1:0] H_LAST   = CORD_W'(H_TOT - 1);
  localparam logic [CORD_W-1:0] V_LAST   = CORD_W'(V_TOT - 1);
  localparam logic [CORD_W-1:0] H_ACT_C  = CORD_W'(H_ACTIVE);
  localparam logic [CORD_W-1:0] V_ACT_C  = CORD_W'(V_ACTIVE);
  localparam logic [CORD_W-1:0] HS_BEG   = CORD_W'(H_ACTIVE + H_FP);
  localparam logic [CORD_W-1:0] HS_END   = CORD_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CORD_W-1:0] VS_BEG   = CORD_W'(V_ACTIVE + V_FP);
  localparam logic [CORD_W-1:0] VS_END   = CORD_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CORD_W-1:0] h, v;
  logic [CORD_W-1:0] h_upd, v_upd;
  logic              h_wrap;
  logic              raw_show, raw_hs_n, raw_vs_n;
  logic              show_q, hs_n_q, vs_n_q;
  logic [2:0]        dly_q;

  // Next counter values. The compare flags are derived from these so the
  // registered flags line up with the registered coordinates. Wrapping on
  // ">=" keeps the counters in range even from an out-of-range value.
  always_comb begin
    h_upd  = h;
    v_upd  = v;
    h_wrap = (h >= H_LAST);
    if (i_pix_en) begin
      if (h_wrap) begin
        h_upd = '0;
        v_upd = (v >= V_LAST) ? '0 : v + CORD_W'(1);
      end else begin
        h_upd = h + CORD_W'(1);
      end
    end
    raw_show = (h_upd < H_ACT_C) && (v_upd < V_ACT_C);
    raw_hs_n = !((h_upd >= HS_BEG) && (h_upd < HS_END));
    raw_vs_n = !((v_upd >= VS_BEG) && (v_upd < VS_END));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h             <= '0;
      v             <= '0;
      show_q        <= 1'b0;
      hs_n_q        <= 1'b1;
      vs_n_q        <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      h             <= h_upd;
      v             <= v_upd;
      show_q        <= raw_show;
      hs_n_q        <= raw_hs_n;
      vs_n_q        <= raw_vs_n;
      // Only a wrapping tick can move v, so this fires once per frame.
      o_frame_start <= i_pix_en && h_wrap && (v_upd == V_ACT_C);
    end
  end

  vga_delay_line #(
    .WIDTH   (3),
    .DEPTH   (SYNC_DELAY),
    .RST_VAL (3'b110)
  ) u_sync_dly (
    .clk (i_clk),
    .rst (i_rst),
    .en  (i_pix_en),
    .d   ({hs_n_q, vs_n_q, show_q}),
    .q   (dly_q)
  );

  assign o_x_cord  = v;
  assign o_y_cord  = h;
  assign o_show_en = show_q;
  assign o_hsync_n = dly_q[2];
  assign o_vsync_n = dly_q[1];
  assign o_blank_n = dly_q[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    int hact; int hfp; int hsw; int hbp;
    int vact; int vfp; int vsw; int vbp;
    int dly;
  } cfg_t;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       show;
    logic       hs;
    logic       vs;
    logic       bl;
    logic       fs;
  } obs_t;

  typedef struct packed {
    int             h;
    int             v;
    logic [2:0]     cur;
    logic [7:0][2:0] pipe;
  } mstate_t;

  // Scaled-down timing so whole frames fit in a short run: 80 x 58.
  localparam int S_HA = 64, S_HFP = 4, S_HSW = 8, S_HBP = 4;
  localparam int S_VA = 48, S_VFP = 3, S_VSW = 2, S_VBP = 5;
  localparam int S_HT = 80, S_VT = 58;

  localparam cfg_t CFG_D0 = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
  localparam cfg_t CFG_D2 = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
  localparam cfg_t CFG_S  = '{S_HA, S_HFP, S_HSW, S_HBP, S_VA, S_VFP, S_VSW, S_VBP, 0};

  // x, y, show, hsync_n, vsync_n, blank_n, frame_start while in reset
  localparam logic [24:0] RST_OBS = {10'd0, 10'd0, 5'b01100};

  logic clk, rst, pix_en;

  logic [9:0] d0_x, d0_y, d2_x, d2_y, s_x, s_y;
  logic d0_show, d0_hs, d0_vs, d0_bl, d0_fs;
  logic d2_show, d2_hs, d2_vs, d2_bl, d2_fs;
  logic s_show, s_hs, s_vs, s_bl, s_fs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mstate_t st0, st2, sts;
  obs_t q0[$], q2[$], qs[$];

  vga_timing_gen #(.SYNC_DELAY(0)) dut_d0 (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x_cord(d0_x), .o_y_cord(d0_y), .o_show_en(d0_show),
    .o_hsync_n(d0_hs), .o_vsync_n(d0_vs), .o_blank_n(d0_bl),
    .o_frame_start(d0_fs));

  vga_timing_gen #(.SYNC_DELAY(2)) dut_d2 (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x_cord(d2_x), .o_y_cord(d2_y), .o_show_en(d2_show),
    .o_hsync_n(d2_hs), .o_vsync_n(d2_vs), .o_blank_n(d2_bl),
    .o_frame_start(d2_fs));

  vga_timing_gen #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HSW), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VSW), .V_BP(S_VBP),
    .SYNC_DELAY(0)
  ) dut_s (
    .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en),
    .o_x_cord(s_x), .o_y_cord(s_y), .o_show_en(s_show),
    .o_hsync_n(s_hs), .o_vsync_n(s_vs), .o_blank_n(s_bl),
    .o_frame_start(s_fs));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Undelayed {hsync_n, vsync_n, show} for a raster position.
  function automatic logic [2:0] raw_of(input cfg_t c, input int h, input int v);
    logic hs_n, vs_n, show;
    hs_n = !(h >= c.hact + c.hfp && h < c.hact + c.hfp + c.hsw);
    vs_n = !(v >= c.vact + c.vfp && v < c.vact + c.vfp + c.vsw);
    show = (h < c.hact) && (v < c.vact);
    return {hs_n, vs_n, show};
  endfunction

  // Reference raster: advances one clock and returns what the outputs must
  // show after that clock edge.
  function automatic void model_step(input cfg_t c, inout mstate_t s,
                                     input logic pe, input logic r, output obs_t e);
    int ht, vt;
    logic [2:0] d;
    logic fs;
    ht = c.hact + c.hfp + c.hsw + c.hbp;
    vt = c.vact + c.vfp + c.vsw + c.vbp;
    fs = 1'b0;
    if (r) begin
      s.h = 0;
      s.v = 0;
      s.cur = 3'b110;
      for (int i = 0; i < 8; i++) s.pipe[i] = 3'b110;
    end else begin
      if (pe) begin
        for (int i = 7; i > 0; i--) s.pipe[i] = s.pipe[i-1];
        s.pipe[0] = s.cur;
        if (s.h == ht - 1) begin
          s.h = 0;
          s.v = (s.v == vt - 1) ? 0 : s.v + 1;
          fs = (s.v == c.vact);
        end else begin
          s.h = s.h + 1;
        end
      end
      s.cur = raw_of(c, s.h, s.v);
    end
    if (c.dly == 0) d = s.cur;
    else            d = s.pipe[c.dly-1];
    e.x    = 10'(s.v);
    e.y    = 10'(s.h);
    e.show = s.cur[0];
    e.hs   = d[2];
    e.vs   = d[1];
    e.bl   = d[0];
    e.fs   = fs;
  endfunction

  // Drive one clock, queue the model's expectation for every instance, then
  // pop and compare once the outputs have settled.
  task automatic tick(input logic pe, input logic r);
    obs_t e, g;
    pix_en = pe;
    rst    = r;
    model_step(CFG_D0, st0, pe, r, e); q0.push_back(e);
    model_step(CFG_D2, st2, pe, r, e); q2.push_back(e);
    model_step(CFG_S,  sts, pe, r, e); qs.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = q0.pop_front();
    g = {d0_x, d0_y, d0_show, d0_hs, d0_vs, d0_bl, d0_fs};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL sb_d0 cyc=%0d got x=%0d y=%0d sh/hs/vs/bl/fs=%b%b%b%b%b exp x=%0d y=%0d sh/hs/vs/bl/fs=%b%b%b%b%b",
               cyc, g.x, g.y, g.show, g.hs, g.vs, g.bl, g.fs, e.x, e.y, e.show, e.hs, e.vs, e.bl, e.fs);
    end
    e = q2.pop_front();
    g = {d2_x, d2_y, d2_show, d2_hs, d2_vs, d2_bl, d2_fs};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL sb_d2 cyc=%0d got x=%0d y=%0d sh/hs/vs/bl/fs=%b%b%b%b%b exp x=%0d y=%0d sh/hs/vs/bl/fs=%b%b%b%b%b",
               cyc, g.x, g.y, g.show, g.hs, g.vs, g.bl, g.fs, e.x, e.y, e.show, e.hs, e.vs, e.bl, e.fs);
    end
    e = qs.pop_front();
    g = {s_x, s_y, s_show, s_hs, s_vs, s_bl, s_fs};
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL sb_small cyc=%0d got x=%0d y=%0d sh/hs/vs/bl/fs=%b%b%b%b%b exp x=%0d y=%0d sh/hs/vs/bl/fs=%b%b%b%b%b",
               cyc, g.x, g.y, g.show, g.hs, g.vs, g.bl, g.fs, e.x, e.y, e.show, e.hs, e.vs, e.bl, e.fs);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      tick(i[0], 1'b1);
      checks++;
      if ({d0_x, d0_y, d0_show, d0_hs, d0_vs, d0_bl, d0_fs} !== RST_OBS) begin
        errors++;
        $display("FAIL reset_d0 got=%h exp=%h", {d0_x, d0_y, d0_show, d0_hs, d0_vs, d0_bl, d0_fs}, RST_OBS);
      end
      checks++;
      if ({d2_x, d2_y, d2_show, d2_hs, d2_vs, d2_bl, d2_fs} !== RST_OBS) begin
        errors++;
        $display("FAIL reset_d2 got=%h exp=%h", {d2_x, d2_y, d2_show, d2_hs, d2_vs, d2_bl, d2_fs}, RST_OBS);
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (s_x !== 10'd0 || s_y !== 10'd1) begin
      errors++;
      $display("FAIL first_tick got x=%0d y=%0d exp x=0 y=1", s_x, s_y);
    end
  endtask

  task automatic test_hsync_d0();
    int first_y, low_cnt, bl_bad;
    first_y = -1; low_cnt = 0; bl_bad = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 800; i++) begin
      tick(1'b1, 1'b0);
      if (d0_hs === 1'b0) begin
        low_cnt++;
        if (first_y < 0) first_y = int'(d0_y);
      end
      if (d0_bl !== d0_show) bl_bad++;
      if (d0_x == 10'd0 && d0_y == 10'd639) begin
        checks++;
        if (d0_show !== 1'b1) begin errors++; $display("FAIL show_0_639 got=%b exp=1", d0_show); end
      end
      if (d0_x == 10'd0 && d0_y == 10'd640) begin
        checks++;
        if (d0_show !== 1'b0) begin errors++; $display("FAIL show_0_640 got=%b exp=0", d0_show); end
      end
    end
    checks++;
    if (first_y != 656) begin errors++; $display("FAIL hsync_start got=%0d exp=656", first_y); end
    checks++;
    if (low_cnt != 96) begin errors++; $display("FAIL hsync_width got=%0d exp=96", low_cnt); end
    checks++;
    if (bl_bad != 0) begin errors++; $display("FAIL blank_eq_show got=%0d diffs exp=0", bl_bad); end
  endtask

  task automatic test_delay_alt();
    int t656, tfall, hold_bad;
    logic [9:0] py;
    t656 = -1; tfall = -1; hold_bad = 0;
    tick(1'b1, 1'b1);
    for (int i = 0; i < 1500 && tfall < 0; i++) begin
      py = d2_y;
      tick((i % 2) == 0, 1'b0);
      if ((i % 2) == 1 && d2_y !== py) hold_bad++;
      if (t656 < 0 && d2_y == 10'd656) t656 = cyc;
      if (tfall < 0 && d2_hs === 1'b0) tfall = cyc;
    end
    checks++;
    if (t656 < 0 || tfall < 0 || (tfall - t656) != 4) begin
      errors++;
      $display("FAIL hsync_delay got=%0d clocks (h656 at %0d, fall at %0d) exp=4", tfall - t656, t656, tfall);
    end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL hold_on_idle got=%0d moves exp=0", hold_bad); end
  endtask

  task automatic test_full_frame();
    int hwrap, wrap_bad, vwrap, fs_cnt, fs_x, fs_y, range_bad, vs_low, vs_first, px, py;
    hwrap = 0; wrap_bad = 0; vwrap = 0; fs_cnt = 0; fs_x = -1; fs_y = -1;
    range_bad = 0; vs_low = 0; vs_first = -1;
    tick(1'b1, 1'b1);
    for (int i = 0; i < S_HT * S_VT + 10; i++) begin
      px = int'(s_x);
      py = int'(s_y);
      tick(1'b1, 1'b0);
      if (py == S_HT - 1 && s_y == 10'd0) begin
        hwrap++;
        if (int'(s_x) != ((px == S_VT - 1) ? 0 : px + 1)) wrap_bad++;
      end
      if (px == S_VT - 1 && s_x == 10'd0) vwrap++;
      if (s_fs === 1'b1) begin fs_cnt++; fs_x = int'(s_x); fs_y = int'(s_y); end
      if (s_x > 10'(S_VT - 1) || s_y > 10'(S_HT - 1)) range_bad++;
      if (s_vs === 1'b0) begin
        vs_low++;
        if (vs_first < 0) vs_first = int'(s_x);
      end
      if (s_x == 10'd47 && s_y == 10'd63) begin
        checks++;
        if (s_show !== 1'b1) begin errors++; $display("FAIL show_47_63 got=%b exp=1", s_show); end
      end
      if ((s_x == 10'd47 && s_y == 10'd64) || (s_x == 10'd48 && s_y == 10'd0) ||
          (s_x == 10'd57 && s_y == 10'd79)) begin
        checks++;
        if (s_show !== 1'b0) begin errors++; $display("FAIL show_edge x=%0d y=%0d got=%b exp=0", s_x, s_y, s_show); end
      end
    end
    checks++;
    if (hwrap != 58 || wrap_bad != 0) begin
      errors++; $display("FAIL h_wraps got=%0d (bad %0d) exp=58 (bad 0)", hwrap, wrap_bad);
    end
    checks++;
    if (vwrap != 1) begin errors++; $display("FAIL v_wraps got=%0d exp=1", vwrap); end
    checks++;
    if (fs_cnt != 1 || fs_x != S_VA || fs_y != 0) begin
      errors++; $display("FAIL frame_start got count=%0d at (%0d,%0d) exp count=1 at (48,0)", fs_cnt, fs_x, fs_y);
    end
    checks++;
    if (range_bad != 0) begin errors++; $display("FAIL range got=%0d exp=0", range_bad); end
    checks++;
    if (vs_low != 2 * S_HT || vs_first != S_VA + S_VFP) begin
      errors++; $display("FAIL vsync_lines got low=%0d first line=%0d exp low=160 first line=51", vs_low, vs_first);
    end
  endtask

  task automatic test_reset_mid();
    int n, fs_seen, fs_x, fs_y;
    tick(1'b1, 1'b1);
    n = 0;
    while (!(s_x == 10'd30 && s_y == 10'd40) && n < 4000) begin
      tick(1'b1, 1'b0);
      n++;
    end
    checks++;
    if (n >= 4000) begin errors++; $display("FAIL reach_30_40 got x=%0d y=%0d exp x=30 y=40", s_x, s_y); end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      checks++;
      if ({s_x, s_y, s_show, s_hs, s_vs, s_bl, s_fs} !== RST_OBS) begin
        errors++;
        $display("FAIL mid_reset got=%h exp=%h", {s_x, s_y, s_show, s_hs, s_vs, s_bl, s_fs}, RST_OBS);
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (s_x !== 10'd0 || s_y !== 10'd1) begin
      errors++; $display("FAIL resume got x=%0d y=%0d exp x=0 y=1", s_x, s_y);
    end
    n = 1; fs_seen = 0; fs_x = -1; fs_y = -1;
    while (fs_seen == 0 && n < 6000) begin
      tick(1'b1, 1'b0);
      n++;
      if (s_fs === 1'b1) begin fs_seen = 1; fs_x = int'(s_x); fs_y = int'(s_y); end
    end
    checks++;
    if (fs_seen == 0 || n != S_VA * S_HT || fs_x != S_VA || fs_y != 0) begin
      errors++;
      $display("FAIL fs_after_reset got tick=%0d at (%0d,%0d) exp tick=3840 at (48,0)", n, fs_x, fs_y);
    end
  endtask

  task automatic test_random_gaps();
    int ticks, fs_cnt, bad, guard;
    logic pe;
    ticks = 0; fs_cnt = 0; bad = 0; guard = 0;
    tick(1'b1, 1'b1);
    while (ticks < 2 * S_HT * S_VT && guard < 40000) begin
      pe = ($urandom_range(0, 3) != 0);
      tick(pe, 1'b0);
      if (pe) ticks++;
      if (s_fs === 1'b1) fs_cnt++;
      if (s_x > 10'(S_VT - 1) || s_y > 10'(S_HT - 1)) bad++;
      guard++;
    end
    checks++;
    if (ticks != 2 * S_HT * S_VT) begin errors++; $display("FAIL rand_budget got=%0d ticks exp=%0d", ticks, 2 * S_HT * S_VT); end
    checks++;
    if (fs_cnt != 2) begin errors++; $display("FAIL rand_frames got=%0d frame_start exp=2", fs_cnt); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rand_range got=%0d exp=0", bad); end
  endtask

  initial begin
    rst    = 1'b1;
    pix_en = 1'b0;
    test_reset();
    test_hsync_d0();
    test_delay_alt();
    test_full_frame();
    test_reset_mid();
    test_random_gaps();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
